// File: rtl/button_index_encoder.sv
// Debounced 4-button index encoder.
// The raw buttons are synchronized and then debounced by a stability counter.
// A small FSM accepts a single pressed button and reports its binary index.
// Chords of two or more buttons are rejected until every button is released.
module button_index_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic [3:0] BTN,
  output logic [1:0] IDX,
  output logic       VALID,
  output logic       STROBE,
  output logic       MULTI
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    BLOCKED
  } state_t;

  logic          rst_meta_q;
  logic          rst_n_q;
  logic [3:0]    s1_q;
  logic [3:0]    s2_q;
  logic [3:0]    s2_prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    db_q;
  logic          stable;
  logic          db_load;
  logic [2:0]    ones;
  logic          db_one;
  logic          db_many;
  logic [1:0]    db_pos;
  state_t        state_q;
  logic [1:0]    idx_q;
  logic          valid_q;
  logic          strobe_q;
  logic          multi_q;

  // Reset asserts immediately but releases only after two clock edges.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  // Stability counter restarts on any change of the synchronized vector.
  always_comb begin
    stable  = (s2_q == s2_prev_q);
    cnt_d   = '0;
    if (stable) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end
    // Loading only on a stable edge keeps a toggle at saturation out of DB.
    db_load = stable && (cnt_q == CNT_MAX);
  end

  // Two-flop synchronizer, history flop, counter and debounced register.
  always_ff @(posedge CLK100MHZ or negedge rst_n_q) begin
    if (!rst_n_q) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s2_prev_q <= '0;
      cnt_q     <= '0;
      db_q      <= '0;
    end else begin
      s1_q      <= BTN;
      s2_q      <= s1_q;
      s2_prev_q <= s2_q;
      cnt_q     <= cnt_d;
      if (db_load) begin
        db_q <= s2_q;
      end
    end
  end

  // Classify the debounced vector as none, exactly one (with position), or many.
  always_comb begin
    ones    = {2'b00, db_q[0]} + {2'b00, db_q[1]} + {2'b00, db_q[2]} + {2'b00, db_q[3]};
    db_one  = (ones == 3'd1);
    db_many = (ones >= 3'd2);
    db_pos  = 2'd0;
    unique case (db_q)
      4'b0010: db_pos = 2'd1;
      4'b0100: db_pos = 2'd2;
      4'b1000: db_pos = 2'd3;
      default: db_pos = 2'd0;
    endcase
  end

  // Acceptance FSM with registered index, valid, strobe and multi outputs.
  always_ff @(posedge CLK100MHZ or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      multi_q  <= db_many;
      unique case (state_q)
        IDLE: begin
          if (db_one) begin
            state_q  <= HELD;
            idx_q    <= db_pos;
            valid_q  <= 1'b1;
            strobe_q <= 1'b1;
          end else if (db_many) begin
            state_q <= BLOCKED;
          end
        end
        HELD: begin
          if (!db_one && !db_many) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else if (db_many || (db_pos != idx_q)) begin
            state_q <= BLOCKED;
            valid_q <= 1'b0;
          end
        end
        BLOCKED: begin
          valid_q <= 1'b0;
          if (!db_one && !db_many) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IDX    = idx_q;
  assign VALID  = valid_q;
  assign STROBE = strobe_q;
  assign MULTI  = multi_q;

endmodule

// File: tb/tb_button_index_encoder.sv
// Bench for button_index_encoder with a 4-cycle debounce window.
// Stimulus pushes expected output events into a queue; a monitor pops and
// compares them as STROBE pulses, VALID falls and MULTI edges appear.
module tb_button_index_encoder;

  localparam int unsigned D   = 4;
  localparam int          LAT = D + 3;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic [1:0] idx;
  logic       valid;
  logic       strobe;
  logic       multi;

  button_index_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rstn),
    .BTN       (btn),
    .IDX       (idx),
    .VALID     (valid),
    .STROBE    (strobe),
    .MULTI     (multi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_STROBE, EV_VFALL, EV_MRISE, EV_MFALL} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         at;
    logic [1:0] idx;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;
  logic prev_valid = 1'b0;
  logic prev_multi = 1'b0;

  task automatic expect_ev(input ev_kind_t k, input int at, input logic [1:0] i);
    ev_t e;
    e.kind = k;
    e.at   = at;
    e.idx  = i;
    expq.push_back(e);
  endtask

  // Drive a new button vector; e is the edge that first samples it.
  task automatic press(input logic [3:0] v, output int e);
    @(negedge clk);
    btn = v;
    e = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_lvl(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic handle(input ev_kind_t k);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%s at cycle %0d idx=%0d, expected none",
               k.name(), cyc, idx);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.at != cyc || e.idx !== idx ||
          (k == EV_STROBE && valid !== 1'b1) || (k == EV_VFALL && strobe !== 1'b0)) begin
        errors++;
        $display("FAIL event: got kind=%s cycle=%0d idx=%0d valid=%0b strobe=%0b, expected kind=%s cycle=%0d idx=%0d",
                 k.name(), cyc, idx, valid, strobe, e.kind.name(), e.at, e.idx);
      end
    end
  endtask

  // Monitor: sample just after each rising edge and match output events.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (strobe === 1'b1)                      handle(EV_STROBE);
      if (prev_valid === 1'b1 && valid === 1'b0) handle(EV_VFALL);
      if (prev_multi === 1'b0 && multi === 1'b1) handle(EV_MRISE);
      if (prev_multi === 1'b1 && multi === 1'b0) handle(EV_MFALL);
      prev_valid = valid;
      prev_multi = multi;
    end
  end

  initial begin
    int e;
    int r;
    #2 rstn = 1'b0;
    idle(3);
    check_lvl("reset_idx", int'(idx), 0);
    check_lvl("reset_valid", int'(valid), 0);
    check_lvl("reset_strobe", int'(strobe), 0);
    check_lvl("reset_multi", int'(multi), 0);
    rstn = 1'b1;
    idle(10);

    // Clean press of button 2, then release.
    press(4'b0100, e);
    expect_ev(EV_STROBE, e + LAT, 2'd2);
    idle(12);
    check_lvl("held_valid", int'(valid), 1);
    press(4'b0000, e);
    expect_ev(EV_VFALL, e + LAT, 2'd2);
    idle(12);
    check_lvl("idx_after_release", int'(idx), 2);

    // Bouncing button 0, then steady and held long past saturation.
    for (int i = 0; i < 10; i++) begin
      press((i % 2 == 0) ? 4'b0001 : 4'b0000, e);
      idle(1);
    end
    press(4'b0001, e);
    expect_ev(EV_STROBE, e + LAT, 2'd0);
    idle(30);
    press(4'b0000, e);
    expect_ev(EV_VFALL, e + LAT, 2'd0);
    idle(12);

    // Chord blocks; reduction to one button does not re-arm.
    press(4'b0011, e);
    expect_ev(EV_MRISE, e + LAT, 2'd0);
    idle(12);
    check_lvl("chord_valid", int'(valid), 0);
    press(4'b0010, e);
    expect_ev(EV_MFALL, e + LAT, 2'd0);
    idle(12);
    press(4'b0000, e);
    idle(12);
    press(4'b0010, e);
    expect_ev(EV_STROBE, e + LAT, 2'd1);
    idle(12);
    press(4'b0000, e);
    expect_ev(EV_VFALL, e + LAT, 2'd1);
    idle(12);

    // Held button 3 switches directly to button 0.
    press(4'b1000, e);
    expect_ev(EV_STROBE, e + LAT, 2'd3);
    idle(12);
    press(4'b0001, e);
    expect_ev(EV_VFALL, e + LAT, 2'd3);
    idle(12);
    press(4'b0000, e);
    idle(12);
    check_lvl("idx_kept_3", int'(idx), 3);
    press(4'b0001, e);
    expect_ev(EV_STROBE, e + LAT, 2'd0);
    idle(12);
    press(4'b0000, e);
    expect_ev(EV_VFALL, e + LAT, 2'd0);
    idle(12);

    // Reset pulse shortly before the strobe; held button re-debounced after release.
    press(4'b1000, e);
    idle(6);
    rstn = 1'b0;
    #1;
    check_lvl("rst_mid_valid", int'(valid), 0);
    check_lvl("rst_mid_strobe", int'(strobe), 0);
    idle(2);
    rstn = 1'b1;
    r = cyc;
    // Two reset-sync edges, then the synchronizer first samples BTN.
    expect_ev(EV_STROBE, r + 3 + LAT, 2'd3);
    idle(20);
    press(4'b0000, e);
    expect_ev(EV_VFALL, e + LAT, 2'd3);
    idle(15);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d outstanding, expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
